// File: rtl/seq_restoring_divider16_pkg.sv
// Shared types and sizes for the sequential restoring divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;
endpackage

// File: rtl/seq_restoring_divider16_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
interface seq_restoring_divider16_if import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider16_trial.sv
// Ripple-borrow subtractor for the trial step, one full-subtractor cell per bit.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module sub_trial17 #(parameter int W = 17) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow_out
);
    logic [W:0] bw;

    assign bw[0] = 1'b0;

    for (genvar g = 0; g < W; g++) begin : g_cell
        fs_cell u_fs (
            .a    (a[g]),
            .b    (b[g]),
            .bin  (bw[g]),
            .d    (diff[g]),
            .bout (bw[g+1])
        );
    end

    assign borrow_out = bw[W];
endmodule

// File: rtl/seq_restoring_divider16.sv
// Unsigned restoring divider: one trial subtraction per clock, WIDTH iterations.
module seq_restoring_divider16 import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
    input logic                    clk,
    input logic                    rst,
    seq_restoring_divider16_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r_reg, q_reg, d_reg;
    logic             busy, done, dbz;
    logic [WIDTH-1:0] quotient, remainder;

    logic [WIDTH:0]   shifted, diff;
    logic             borrow, take;
    logic [WIDTH-1:0] new_r, new_q;

    assign shifted = {r_reg, q_reg[WIDTH-1]};

    sub_trial17 #(.W(WIDTH + 1)) u_trial (
        .a          (shifted),
        .b          ({1'b0, d_reg}),
        .diff       (diff),
        .borrow_out (borrow)
    );

    // Since R < D, a non-negative trial always has MSB 0, so both flags agree.
    assign take  = ~(diff[WIDTH] | borrow);
    assign new_r = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign new_q = {q_reg[WIDTH-2:0], take};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            d_reg <= bus.divisor;
                            q_reg <= bus.dividend;
                            r_reg <= '0;
                            cnt   <= '0;
                            dbz   <= 1'b0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end else begin
                            quotient  <= '1;
                            remainder <= bus.dividend;
                            dbz       <= 1'b1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                CALC: begin
                    r_reg <= new_r;
                    q_reg <= new_q;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quotient  <= new_q;
                        remainder <= new_r;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_restoring_divider16.sv
// Directed bench for the restoring divider: latency, results, zero divisor, ignored start, reset.
module tb_seq_restoring_divider16;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    seq_restoring_divider16_if #(.WIDTH(DIV_WIDTH)) bus ();

    seq_restoring_divider16 #(.WIDTH(DIV_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts negedges after acceptance until done (bounded at 40).
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy) bcnt++;
            if (bus.done) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic ez,
                          input int elat, input int ebusy);
        int lat, bcnt;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 16'h5A5A;
        bus.divisor  = 16'h0003;
        wait_done(lat, bcnt);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " busy cycles"}, bcnt, ebusy);
        chk({tag, " quotient"}, bus.quotient, eq);
        chk({tag, " remainder"}, bus.remainder, er);
        chk({tag, " div_by_zero"}, bus.div_by_zero, ez);
        @(negedge clk);
        chk({tag, " done pulse width"}, bus.done, 0);
        chk({tag, " quotient held"}, bus.quotient, eq);
    endtask

    initial begin
        int lat, bcnt;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset quotient", bus.quotient, 0);
        chk("reset remainder", bus.remainder, 0);
        chk("reset dbz", bus.div_by_zero, 0);

        run_op("100/7",     16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17, 16);
        run_op("FFFF/FFFF", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17, 16);
        run_op("FFFF/1",    16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17, 16);
        run_op("5/9",       16'd5,    16'd9,    16'd0,    16'd5,    1'b0, 17, 16);
        run_op("ABCD/100",  16'hABCD, 16'h0100, 16'h00AB, 16'h00CD, 1'b0, 17, 16);
        run_op("1234/0",    16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1,  0);
        run_op("1000/3",    16'd1000, 16'd3,    16'd333,  16'd1,    1'b0, 17, 16);

        // start pulsed mid-calculation with new operands must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 16'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 16'd5;
            end else if (lat == 6) begin
                bus.start = 1'b0; bus.dividend = 16'd1; bus.divisor = 16'd1;
            end
            if (bus.done) break;
        end
        chk("ignored start latency", lat, 17);
        chk("ignored start quotient", bus.quotient, 14);
        chk("ignored start remainder", bus.remainder, 2);

        // start held through DONE: not taken in DONE, taken in following IDLE
        bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 16'd2;
        @(negedge clk);
        chk("held start idle busy", bus.busy, 0);
        chk("held start idle done", bus.done, 0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, bcnt);
        chk("held start latency", lat, 17);
        chk("held start quotient", bus.quotient, 4);
        chk("held start remainder", bus.remainder, 1);

        // reset in the middle of a calculation
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 16'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre-reset busy", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid reset busy", bus.busy, 0);
        chk("mid reset done", bus.done, 0);
        chk("mid reset quotient", bus.quotient, 0);
        chk("mid reset remainder", bus.remainder, 0);
        chk("mid reset dbz", bus.div_by_zero, 0);
        run_op("1000/3 after reset", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 17, 16);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
